sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Two-port round-robin arbiter in front of an SDRAM controller's command FIFO.
// Reads are tagged with the requesting port index in an in-order tag queue so
// that returning data (read-response FIFO, show-ahead) is routed back to the
// port that issued it, with a fixed one-cycle latency from the pop.
//
// Ports
//   clk, reset_n                  : clock, asynchronous active-low reset
//   pN_req/write/addr/wdata (N=0,1): port request, 1 = write / 0 = read
//   pN_ready                      : request accepted this cycle (combinational)
//   pN_rvalid/pN_rdata            : registered read-data strobe and data
//   cmd_push/cmd_din/cmd_full     : command FIFO write side, {write, addr, wdata}
//   rsp_pop/rsp_dout/rsp_empty    : response FIFO read side
module sdram_arbiter #(
    parameter int AW     = 24,
    parameter int DW     = 16,
    parameter int MAX_RD = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                p0_req,
    input  logic                p0_write,
    input  logic [AW-1:0]       p0_addr,
    input  logic [DW-1:0]       p0_wdata,
    output logic                p0_ready,
    output logic                p0_rvalid,
    output logic [DW-1:0]       p0_rdata,
    input  logic                p1_req,
    input  logic                p1_write,
    input  logic [AW-1:0]       p1_addr,
    input  logic [DW-1:0]       p1_wdata,
    output logic                p1_ready,
    output logic                p1_rvalid,
    output logic [DW-1:0]       p1_rdata,
    output logic                cmd_push,
    output logic [AW+DW:0]      cmd_din,
    input  logic                cmd_full,
    output logic                rsp_pop,
    input  logic [DW-1:0]       rsp_dout,
    input  logic                rsp_empty
);

    localparam int PW = $clog2(MAX_RD);
    localparam int CW = $clog2(MAX_RD) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RD);

    logic              last_grant_r;
    logic [CW-1:0]     rd_cnt_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [MAX_RD-1:0] tag_q_r;
    logic              p0_rvalid_r;
    logic              p1_rvalid_r;
    logic [DW-1:0]     p0_rdata_r;
    logic [DW-1:0]     p1_rdata_r;

    logic              rd_room_s;
    logic              elig0_s;
    logic              elig1_s;
    logic              grant_s;
    logic              grant_idx_s;
    logic              grant_write_s;
    logic [AW-1:0]     grant_addr_s;
    logic [DW-1:0]     grant_wdata_s;
    logic [AW+DW:0]    cmd_din_s;
    logic              push_tag_s;
    logic              pop_s;
    logic              pop_tag_s;

    // Eligibility and round-robin grant; reset_n gating keeps every request-side output low during reset.
    always_comb begin
        rd_room_s   = (rd_cnt_r < MAX_CNT);
        elig0_s     = reset_n & p0_req & ~cmd_full & (p0_write | rd_room_s);
        elig1_s     = reset_n & p1_req & ~cmd_full & (p1_write | rd_room_s);
        grant_s     = 1'b0;
        grant_idx_s = 1'b0;
        if (elig0_s && elig1_s) begin
            grant_s     = 1'b1;
            grant_idx_s = ~last_grant_r;
        end else if (elig0_s) begin
            grant_s     = 1'b1;
            grant_idx_s = 1'b0;
        end else if (elig1_s) begin
            grant_s     = 1'b1;
            grant_idx_s = 1'b1;
        end else begin
            grant_s     = 1'b0;
            grant_idx_s = 1'b0;
        end
    end

    // Command word of the granted port; write data is zeroed for reads so the word is deterministic.
    always_comb begin
        grant_write_s = 1'b0;
        grant_addr_s  = {AW{1'b0}};
        grant_wdata_s = {DW{1'b0}};
        cmd_din_s     = {(AW+DW+1){1'b0}};
        if (grant_idx_s) begin
            grant_write_s = p1_write;
            grant_addr_s  = p1_addr;
            grant_wdata_s = p1_wdata;
        end else begin
            grant_write_s = p0_write;
            grant_addr_s  = p0_addr;
            grant_wdata_s = p0_wdata;
        end
        if (grant_s) begin
            cmd_din_s = {grant_write_s, grant_addr_s, grant_write_s ? grant_wdata_s : {DW{1'b0}}};
        end else begin
            cmd_din_s = {(AW+DW+1){1'b0}};
        end
    end

    assign push_tag_s = grant_s & ~grant_write_s;
    // Only pop what was actually requested; an unsolicited response stays in the FIFO.
    assign pop_s      = reset_n & ~rsp_empty & (rd_cnt_r != {CW{1'b0}});
    assign pop_tag_s  = tag_q_r[rd_ptr_r];

    assign p0_ready   = grant_s & ~grant_idx_s;
    assign p1_ready   = grant_s & grant_idx_s;
    assign cmd_push   = grant_s;
    assign cmd_din    = cmd_din_s;
    assign rsp_pop    = pop_s;
    assign p0_rvalid  = p0_rvalid_r;
    assign p1_rvalid  = p1_rvalid_r;
    assign p0_rdata   = p0_rdata_r;
    assign p1_rdata   = p1_rdata_r;

    // Remember the last granted port so that ties alternate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= 1'b1;
        end else if (grant_s) begin
            last_grant_r <= grant_idx_s;
        end
    end

    // Tag queue and outstanding-read count; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_r <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            tag_q_r  <= {MAX_RD{1'b0}};
        end else begin
            if (push_tag_s) begin
                tag_q_r[wr_ptr_r] <= grant_idx_s;
                wr_ptr_r          <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_tag_s, pop_s})
                2'b10:   rd_cnt_r <= rd_cnt_r + CW'(1);
                2'b01:   rd_cnt_r <= rd_cnt_r - CW'(1);
                default: rd_cnt_r <= rd_cnt_r;
            endcase
        end
    end

    // Route popped data to the tagged port one cycle after the pop; rdata holds between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            p0_rdata_r  <= {DW{1'b0}};
            p1_rdata_r  <= {DW{1'b0}};
        end else begin
            p0_rvalid_r <= pop_s & ~pop_tag_s;
            p1_rvalid_r <= pop_s & pop_tag_s;
            if (pop_s && !pop_tag_s) begin
                p0_rdata_r <= rsp_dout;
            end
            if (pop_s && pop_tag_s) begin
                p1_rdata_r <= rsp_dout;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a table of directed vectors, hand
// sequences for the multi-cycle corners, and a randomized phase, all checked
// against a queue-based behavioural model of the arbiter.
module tb_sdram_arbiter;

    localparam int AW     = 24;
    localparam int DW     = 16;
    localparam int MAX_RD = 4;
    localparam int CMDW   = 1 + AW + DW;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            p0_req, p0_write, p1_req, p1_write;
    logic [AW-1:0]   p0_addr, p1_addr;
    logic [DW-1:0]   p0_wdata, p1_wdata;
    logic            p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [DW-1:0]   p0_rdata, p1_rdata;
    logic            cmd_push, cmd_full, rsp_pop, rsp_empty;
    logic [CMDW-1:0] cmd_din;
    logic [DW-1:0]   rsp_dout;

    sdram_arbiter #(.AW(AW), .DW(DW), .MAX_RD(MAX_RD)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .cmd_push(cmd_push), .cmd_din(cmd_din), .cmd_full(cmd_full),
        .rsp_pop(rsp_pop), .rsp_dout(rsp_dout), .rsp_empty(rsp_empty)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: outstanding read tags in grant order.
    int            tagq[$];
    int            lg;
    logic          m_rv0, m_rv1;
    logic [DW-1:0] m_rd0, m_rd1;

    // Values sampled at the most recent negedge.
    logic            s_p0_ready, s_p1_ready, s_push, s_pop, s_rv0, s_rv1;
    logic [DW-1:0]   s_rd0, s_rd1;
    logic [CMDW-1:0] s_din;

    typedef struct {
        logic p0r, p0w, p1r, p1w, full, empty;
        logic e0, e1, epush, epop;
    } vec_t;
    vec_t tbl[6];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void model_clear();
        tagq.delete();
        lg    = 1;
        m_rv0 = 1'b0;
        m_rv1 = 1'b0;
        m_rd0 = '0;
        m_rd1 = '0;
    endfunction

    task automatic cycle();
        logic e0, e1, ep;
        int g, ptag;
        logic [CMDW-1:0] ed;
        logic [DW-1:0] pdat;
        e0 = reset_n && p0_req && !cmd_full && (p0_write || tagq.size() < MAX_RD);
        e1 = reset_n && p1_req && !cmd_full && (p1_write || tagq.size() < MAX_RD);
        g = -1;
        if (e0 && e1) g = (lg == 0) ? 1 : 0;
        else if (e0) g = 0;
        else if (e1) g = 1;
        ed = '0;
        if (g == 0) ed = {p0_write, p0_addr, p0_write ? p0_wdata : 16'h0000};
        if (g == 1) ed = {p1_write, p1_addr, p1_write ? p1_wdata : 16'h0000};
        ep = reset_n && !rsp_empty && (tagq.size() != 0);
        @(negedge clk);
        s_p0_ready = p0_ready; s_p1_ready = p1_ready; s_push = cmd_push; s_pop = rsp_pop;
        s_rv0 = p0_rvalid; s_rv1 = p1_rvalid; s_rd0 = p0_rdata; s_rd1 = p1_rdata; s_din = cmd_din;
        chk("p0_ready", 64'(p0_ready), 64'(g == 0));
        chk("p1_ready", 64'(p1_ready), 64'(g == 1));
        chk("cmd_push", 64'(cmd_push), 64'(g >= 0));
        chk("cmd_din", 64'(cmd_din), 64'(ed));
        chk("rsp_pop", 64'(rsp_pop), 64'(ep));
        chk("p0_rvalid", 64'(p0_rvalid), 64'(m_rv0));
        chk("p1_rvalid", 64'(p1_rvalid), 64'(m_rv1));
        chk("p0_rdata", 64'(p0_rdata), 64'(m_rd0));
        chk("p1_rdata", 64'(p1_rdata), 64'(m_rd1));
        ptag = ep ? tagq[0] : -1;
        pdat = rsp_dout;
        @(posedge clk);
        if (!reset_n) begin
            model_clear();
        end else begin
            m_rv0 = 1'b0;
            m_rv1 = 1'b0;
            if (ep) begin
                tagq.delete(0);
                if (ptag == 0) begin m_rv0 = 1'b1; m_rd0 = pdat; end
                else begin m_rv1 = 1'b1; m_rd1 = pdat; end
            end
            if (g >= 0) begin
                lg = g;
                if ((g == 0) ? !p0_write : !p1_write) tagq.push_back(g);
            end
        end
        #1;
    endtask

    task automatic set_req(logic r0, logic w0, logic r1, logic w1);
        p0_req = r0; p0_write = w0; p1_req = r1; p1_write = w1;
    endtask

    task automatic drain(int n);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            rsp_empty = 1'b0;
            rsp_dout  = DW'($urandom);
            cycle();
        end
        rsp_empty = 1'b1;
        cycle();
    endtask

    initial begin
        model_clear();
        reset_n = 1'b0;
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        p0_addr = 24'h000100; p1_addr = 24'h000200;
        p0_wdata = 16'h1234;  p1_wdata = 16'h5678;
        cmd_full = 1'b0; rsp_empty = 1'b0; rsp_dout = 16'hAAAA;
        // Reset holds all request-side outputs low even with requests pending.
        cycle();
        cycle();
        chk("reset_no_ready", 64'({s_p0_ready, s_p1_ready, s_push, s_pop}), 64'h0);
        reset_n = 1'b1;

        // Both ports read continuously, no responses: alternation then stall at MAX_RD.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_req(tbl[i].p0r, tbl[i].p0w, tbl[i].p1r, tbl[i].p1w);
            cmd_full = tbl[i].full; rsp_empty = tbl[i].empty;
            cycle();
            chk("tbl_p0_ready", 64'(s_p0_ready), 64'(tbl[i].e0));
            chk("tbl_p1_ready", 64'(s_p1_ready), 64'(tbl[i].e1));
            chk("tbl_cmd_push", 64'(s_push), 64'(tbl[i].epush));
            chk("tbl_rsp_pop", 64'(s_pop), 64'(tbl[i].epop));
        end
        drain(4);

        // Lone write from p1 is pushed in the same cycle and never produces rvalid.
        set_req(1'b0, 1'b0, 1'b1, 1'b1);
        p1_addr = 24'h000010; p1_wdata = 16'hBEEF;
        cycle();
        chk("wr_p1_ready", 64'(s_p1_ready), 64'h1);
        chk("wr_cmd_din", 64'(s_din), 64'({1'b1, 24'h000010, 16'hBEEF}));
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        rsp_empty = 1'b0; rsp_dout = 16'h7777;
        cycle();
        cycle();
        chk("wr_no_pop", 64'(s_pop), 64'h0);
        chk("wr_no_rvalid", 64'({s_rv0, s_rv1}), 64'h0);
        rsp_empty = 1'b1;

        // Reads p0, p1, p0 then responses routed in issue order.
        set_req(1'b1, 1'b0, 1'b0, 1'b0); cycle();
        set_req(1'b0, 1'b0, 1'b1, 1'b0); cycle();
        set_req(1'b1, 1'b0, 1'b0, 1'b0); cycle();
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        rsp_empty = 1'b0; rsp_dout = 16'h1111; cycle();
        chk("ord_pop1", 64'(s_pop), 64'h1);
        rsp_dout = 16'h2222; cycle();
        chk("ord_rsp1", 64'({s_rv0, s_rv1, s_rd0}), 64'({2'b10, 16'h1111}));
        rsp_dout = 16'h3333; cycle();
        chk("ord_rsp2", 64'({s_rv0, s_rv1, s_rd1}), 64'({2'b01, 16'h2222}));
        rsp_empty = 1'b1; cycle();
        chk("ord_rsp3", 64'({s_rv0, s_rv1, s_rd0}), 64'({2'b10, 16'h3333}));

        // cmd_full blocks everything; afterwards the tie goes to p1 (p0 was last).
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        cmd_full = 1'b1;
        cycle();
        chk("full_no_push", 64'({s_p0_ready, s_p1_ready, s_push}), 64'h0);
        cycle();
        cmd_full = 1'b0;
        cycle();
        chk("full_tie_p1", 64'({s_p0_ready, s_p1_ready}), 64'h1);
        drain(1);

        // Fill to MAX_RD, then pop while still requesting: grant coincides with pop across the wrap.
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        for (int i = 0; i < 10; i++) begin
            rsp_empty = 1'b0;
            rsp_dout  = DW'(16'hC000 + i);
            cycle();
            if (i >= 1) chk("wrap_pop_and_grant", 64'({s_pop, s_push}), 64'h3);
        end
        drain(4);

        // Reset with two reads outstanding discards them; stale responses are not popped.
        set_req(1'b1, 1'b0, 1'b0, 1'b0); cycle();
        set_req(1'b0, 1'b0, 1'b1, 1'b0); cycle();
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        model_clear();
        cycle();
        reset_n = 1'b1;
        rsp_empty = 1'b0; rsp_dout = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_no_pop", 64'({s_pop, s_rv0, s_rv1}), 64'h0);
        end
        rsp_empty = 1'b1;
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        chk("rst_tie_p0", 64'({s_p0_ready, s_p1_ready}), 64'h2);
        drain(1);

        // Randomized traffic against the model, with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            set_req($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4);
            p0_addr = AW'($urandom); p1_addr = AW'($urandom);
            p0_wdata = DW'($urandom); p1_wdata = DW'($urandom);
            cmd_full = ($urandom_range(0, 9) < 2);
            rsp_empty = ($urandom_range(0, 9) < 5);
            rsp_dout = DW'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                model_clear();
                cycle();
                reset_n = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
